// File: rtl/seq_mac_unit.sv
// seq_mac_unit: radix-2 shift-add multiply-accumulate lane, one add-and-shift step per clock,
// signed/unsigned operands and an optional wrapping running accumulator.
module seq_mac_unit #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [ACC_WIDTH-1:0]   acc_out
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, lo_q, lo_d, lo_n;
  logic [WIDTH:0] hi_q, hi_d, hi_n, mcand_ext, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sgn_q, sgn_d, acc_en_q, acc_en_d, last, run, fin, load;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_n;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, prod_ext;
  always_comb begin
    run = state_q == RUN;
    last = cnt_q == CW'(WIDTH-1);
    fin = run && last;
    load = !run && start;
    mcand_ext = {sgn_q & mcand_q[WIDTH-1], mcand_q};
    // the multiplier's sign bit carries weight -2^(W-1), hence the final subtract
    sum = !lo_q[0] ? hi_q : (sgn_q && last) ? hi_q - mcand_ext : hi_q + mcand_ext;
    hi_n = {sgn_q & sum[WIDTH], sum[WIDTH:1]};
    lo_n = {sum[0], lo_q[WIDTH-1:1]};
    prod_n = {hi_n[WIDTH-1:0], lo_n};
    prod_ext = sgn_q ? ACC_WIDTH'($signed(prod_n)) : ACC_WIDTH'(prod_n);
    state_d = load ? RUN : fin ? DONE : run ? RUN : IDLE;
    mcand_d = load ? a : mcand_q;
    hi_d = load ? '0 : run ? hi_n : hi_q;
    lo_d = load ? b : run ? lo_n : lo_q;
    cnt_d = load ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    sgn_d = load ? signed_mode : sgn_q;
    acc_en_d = load ? acc_en : acc_en_q;
    prod_d = fin ? prod_n : prod_q;
    acc_d = (acc_clr ? '0 : acc_q) + ((fin && acc_en_q) ? prod_ext : '0);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      acc_en_q <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      acc_en_q <= acc_en_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
    end
  end
  assign busy    = state_q == RUN;
  assign done    = state_q == DONE;
  assign product = prod_q;
  assign acc_out = acc_q;
endmodule

// File: tb/tb_seq_mac_unit.sv
// tb_seq_mac_unit: table vectors, hazard/reset sequences and random operations against an
// arithmetic reference model; a second instance with a 16-bit accumulator checks wrapping.
module tb_seq_mac_unit;
  logic clk = 1'b0;
  logic reset_n, start, signed_mode, acc_en, acc_clr;
  logic [7:0] a, b;
  logic busy, done, busy2, done2;
  logic [15:0] product, prod2, acc2;
  logic [23:0] acc_out;
  logic [23:0] acc_m;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mac_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
    .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .acc_out(acc_out)
  );

  seq_mac_unit #(.WIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
    .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
    .busy(busy2), .done(done2), .product(prod2), .acc_out(acc2)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic        e;
    logic [15:0] exp_prod;
    logic [23:0] exp_acc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mul_ref(input logic [7:0] x, input logic [7:0] y, input logic s);
    longint p;
    p = s ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
    return p[15:0];
  endfunction

  function automatic logic [23:0] ext_ref(input logic [15:0] p, input logic s);
    longint v;
    v = s ? longint'($signed(p)) : longint'(p);
    return v[23:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits for its completion; operands are scrambled while busy.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic s, input logic e,
                        output int cyc, output int bcnt);
    logic [15:0] ep;
    ep = mul_ref(ta, tb, s);
    a = ta; b = tb; signed_mode = s; acc_en = e; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom); acc_en = 1'($urandom);
    cyc = 1;
    bcnt = 0;
    while (!done && cyc < 30) begin
      bcnt += int'(busy && busy2);
      tick();
      cyc++;
    end
    chk("done_seen", {31'd0, done && done2}, 32'd1);
    if (done) begin
      if (e) acc_m = acc_m + ext_ref(ep, s);
      chk("product", {16'd0, product}, {16'd0, ep});
      chk("product16", {16'd0, prod2}, {16'd0, ep});
      chk("acc", {8'd0, acc_out}, {8'd0, acc_m});
      chk("acc16", {16'd0, acc2}, {16'd0, acc_m[15:0]});
    end
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    acc_m = '0;
    chk("acc_clr", {8'd0, acc_out}, 32'd0);
  endtask

  initial begin
    vec_t vecs[10];
    int cyc, bcnt, t1, n;
    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 24'h000000};
    vecs[1] = '{8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 24'h000000};
    vecs[2] = '{8'hFF, 8'h7F, 1'b1, 1'b0, 16'hFF81, 24'h000000};
    vecs[3] = '{8'h7F, 8'h80, 1'b1, 1'b0, 16'hC080, 24'h000000};
    vecs[4] = '{8'h00, 8'hFB, 1'b1, 1'b0, 16'h0000, 24'h000000};
    vecs[5] = '{8'h03, 8'h04, 1'b1, 1'b1, 16'h000C, 24'h00000C};
    vecs[6] = '{8'hFB, 8'h02, 1'b1, 1'b1, 16'hFFF6, 24'h000002};
    vecs[7] = '{8'h07, 8'h07, 1'b1, 1'b0, 16'h0031, 24'h000002};
    vecs[8] = '{8'hFE, 8'h04, 1'b1, 1'b1, 16'hFFF8, 24'hFFFFFA};
    vecs[9] = '{8'h04, 8'h04, 1'b1, 1'b1, 16'h0010, 24'h00000A};
    reset_n = 1'b0; start = 1'b0; signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    a = '0; b = '0; acc_m = '0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", {16'd0, product}, 32'd0);
    chk("reset_acc", {8'd0, acc_out}, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, cyc, bcnt);
      chk($sformatf("vec%0d_product", i), {16'd0, product}, {16'd0, vecs[i].exp_prod});
      chk($sformatf("vec%0d_acc", i), {8'd0, acc_out}, {8'd0, vecs[i].exp_acc});
      if (i == 0) begin
        chk("latency_cycles", cyc, 32'd9);
        chk("busy_cycles", bcnt, 32'd8);
      end
    end
    tick();
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    clear_acc();

    // start pulsed mid-run with new operands is ignored
    a = 8'd3; b = 8'd5; signed_mode = 1'b0; acc_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'd9; b = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("hazard_done", {31'd0, done}, 32'd1);
    chk("hazard_product", {16'd0, product}, 32'd15);
    tick();
    chk("hazard_no_restart", {31'd0, busy}, 32'd0);

    // start held high: results are one per WIDTH+1 cycles
    a = 8'd2; b = 8'd3; signed_mode = 1'b0; acc_en = 1'b0; start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    t1 = n;
    chk("held_first_product", {16'd0, product}, 32'd6);
    tick();
    n++;
    while (!done && n < 40) begin tick(); n++; end
    chk("held_spacing", n - t1, 32'd9);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("held_third_done", {31'd0, done}, 32'd1);
    tick();
    chk("held_stops", {30'd0, busy, done}, 32'd0);

    // acc_clr coinciding with the completion edge: acc becomes the new product
    run_op(8'd10, 8'd10, 1'b0, 1'b1, cyc, bcnt);
    a = 8'd5; b = 8'd6; signed_mode = 1'b0; acc_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    acc_m = 24'd30;
    chk("clr_acc_done", {31'd0, done}, 32'd1);
    chk("clr_acc_value", {8'd0, acc_out}, 32'd30);
    chk("clr_acc16_value", {16'd0, acc2}, 32'd30);
    tick();

    // asynchronous reset mid-run aborts without a completion
    a = 8'd200; b = 8'd100; signed_mode = 1'b0; acc_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_product", {16'd0, product}, 32'd0);
    chk("async_acc", {8'd0, acc_out}, 32'd0);
    acc_m = '0;
    tick(); tick();
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin tick(); n += int'(done || busy); end
    chk("no_done_after_reset", n, 32'd0);
    run_op(8'd12, 8'd11, 1'b0, 1'b1, cyc, bcnt);
    chk("post_reset_latency", cyc, 32'd9);

    // accumulator wrap: 255*255 twice into the 16-bit instance
    clear_acc();
    run_op(8'hFF, 8'hFF, 1'b0, 1'b1, cyc, bcnt);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b1, cyc, bcnt);
    chk("wrap16", {16'd0, acc2}, 32'h0000FC02);
    chk("wrap24", {8'd0, acc_out}, 32'h0001FC02);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) clear_acc();
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), cyc, bcnt);
      if (i % 37 == 0) chk("rand_latency", cyc, 32'd9);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
